// File: rtl/mul_cell_sched_pkg.sv
// mul_cell_sched_pkg: shared FSM state type and partial-product fold for mul_cell_sched.
package mul_cell_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  localparam int PP_SHIFT = 16;
  function automatic logic [31:0] fold_pp(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3);
    logic [32:0] s;
    s = {1'b0, p2} + {1'b0, p3};
    // only the bits that land below bit 32 after the shift matter
    return p1 + {s[31-PP_SHIFT:0], {PP_SHIFT{1'b0}}};
  endfunction
endpackage

// File: rtl/mul_cell_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching from last+1 modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);
  logic [IDX_W-1:0] j;
  // scan from lowest priority to highest so the closest hit after last wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (en_i && req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/mul_cell_sched.sv
// mul_cell_sched: round-robin sharing of one registered 16x16 partial-product cell for 32x32 low-word multiplies.
module mul_cell_sched
  import mul_cell_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_data,
  output logic [31:0]           mul_src1,
  output logic [31:0]           mul_src2,
  output logic                  mul_en,
  input  logic [31:0]           mul_p1,
  input  logic [31:0]           mul_p2,
  input  logic [31:0]           mul_p3
);
  state_t state_q, state_d;
  logic [ID_W-1:0] last_q, last_d, id_q, id_d, gnt_idx;
  logic [31:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [31:0] a_arr [NUM_REQ];
  logic [31:0] b_arr [NUM_REQ];
  logic [NUM_REQ-1:0] gnt;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end
  // reset gates the grant so req_ready reads zero while reset is held
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .req_i  (req_valid),
    .last_i (last_q),
    .en_i   (state_q == IDLE && !reset),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx)
  );
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = ISSUE;
        last_d = gnt_idx;
        id_d = gnt_idx;
        a_d = a_arr[gnt_idx];
        b_d = b_arr[gnt_idx];
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        state_d = RESP;
        data_d = fold_pp(mul_p1, mul_p2, mul_p3);
      end
      default: state_d = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= ID_W'(NUM_REQ - 1);
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
    end
  end
  assign req_ready = gnt;
  assign rsp_valid = state_q == RESP;
  assign rsp_id = id_q;
  assign rsp_data = data_q;
  assign mul_src1 = a_q;
  assign mul_src2 = b_q;
  assign mul_en = state_q == ISSUE;
endmodule

// File: tb/tb_mul_cell_sched.sv
// tb_mul_cell_sched: directed scoreboard bench for mul_cell_sched with 2 and 4 requesters.
module tb_mul_cell_sched;
  typedef struct packed {logic [2:0] id; logic [31:0] data;} exp_t;
  logic clk, reset;
  logic [1:0] rv, rdy;
  logic [63:0] ra, rb;
  logic rr, rsp_v, rsp_id;
  logic [31:0] rsp_d, s1, s2, p1, p2, p3;
  logic en;
  logic [3:0] rv4, rdy4;
  logic [127:0] ra4, rb4;
  logic rr4, rsp_v4, en4;
  logic [1:0] rsp_id4;
  logic [31:0] rsp_d4, s14, s24, p14, p24, p34;
  logic [7:0] gw2, gw4;
  exp_t q2[$], q4[$];
  exp_t e2, e4;
  int errs = 0, checks = 0;

  mul_cell_sched #(.NUM_REQ(2)) u2 (
    .clk(clk), .reset(reset), .req_valid(rv), .req_ready(rdy), .req_a(ra), .req_b(rb),
    .rsp_valid(rsp_v), .rsp_ready(rr), .rsp_id(rsp_id), .rsp_data(rsp_d),
    .mul_src1(s1), .mul_src2(s2), .mul_en(en), .mul_p1(p1), .mul_p2(p2), .mul_p3(p3));
  mul_cell_sched #(.NUM_REQ(4)) u4 (
    .clk(clk), .reset(reset), .req_valid(rv4), .req_ready(rdy4), .req_a(ra4), .req_b(rb4),
    .rsp_valid(rsp_v4), .rsp_ready(rr4), .rsp_id(rsp_id4), .rsp_data(rsp_d4),
    .mul_src1(s14), .mul_src2(s24), .mul_en(en4), .mul_p1(p14), .mul_p2(p24), .mul_p3(p34));

  assign gw2 = {6'b0, rdy};
  assign gw4 = {4'b0, rdy4};

  initial clk = 0;
  always #5 clk = ~clk;

  // registered partial-product cells, one per DUT
  always @(posedge clk) if (en) begin
    p1 <= {16'b0, s1[15:0]} * {16'b0, s2[15:0]};
    p2 <= {16'b0, s1[15:0]} * {16'b0, s2[31:16]};
    p3 <= {16'b0, s1[31:16]} * {16'b0, s2[15:0]};
  end
  always @(posedge clk) if (en4) begin
    p14 <= {16'b0, s14[15:0]} * {16'b0, s24[15:0]};
    p24 <= {16'b0, s14[15:0]} * {16'b0, s24[31:16]};
    p34 <= {16'b0, s14[31:16]} * {16'b0, s24[15:0]};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    mk.id = 3'(id);
    mk.data = p[31:0];
  endfunction

  always @(negedge clk) if (!reset && rsp_v && rr) begin
    chk("rsp2 pending", 64'(q2.size() != 0), 64'd1);
    if (q2.size() != 0) begin
      e2 = q2.pop_front();
      chk("rsp2 id", 64'(rsp_id), 64'(e2.id));
      chk("rsp2 data", 64'(rsp_d), 64'(e2.data));
    end
  end
  always @(negedge clk) if (!reset && rsp_v4 && rr4) begin
    chk("rsp4 pending", 64'(q4.size() != 0), 64'd1);
    if (q4.size() != 0) begin
      e4 = q4.pop_front();
      chk("rsp4 id", 64'(rsp_id4), 64'(e4.id));
      chk("rsp4 data", 64'(rsp_d4), 64'(e4.data));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_gnt(input string tag, input bit sel, input logic [7:0] exp);
    int n = 0;
    #1;
    while ((sel ? gw4 : gw2) == 8'd0 && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk(tag, 64'(sel ? gw4 : gw2), 64'(exp));
  endtask

  task automatic drain(input string tag, input bit sel);
    int n = 0;
    while ((sel ? q4.size() : q2.size()) != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 64'(sel ? q4.size() : q2.size()), 64'd0);
  endtask

  task automatic op(input string tag, input int id, input logic [31:0] a, input logic [31:0] b);
    ra[32*id +: 32] = a;
    rb[32*id +: 32] = b;
    rv = '0;
    rv[id] = 1'b1;
    q2.push_back(mk(id, a, b));
    wait_gnt(tag, 1'b0, 8'(1 << id));
    tick();
    rv = '0;
    drain({tag, " drain"}, 1'b0);
  endtask

  task automatic chk_idle2(input string tag);
    chk({tag, " req_ready"}, 64'(rdy), 64'd0);
    chk({tag, " rsp_valid"}, 64'(rsp_v), 64'd0);
    chk({tag, " rsp_id"}, 64'(rsp_id), 64'd0);
    chk({tag, " rsp_data"}, 64'(rsp_d), 64'd0);
    chk({tag, " src1"}, 64'(s1), 64'd0);
    chk({tag, " src2"}, 64'(s2), 64'd0);
    chk({tag, " mul_en"}, 64'(en), 64'd0);
  endtask

  initial begin
    int k, n, last_t;
    reset = 1;
    rv = 2'b01; ra = '0; rb = '0; rr = 1;
    rv4 = 4'b1000; ra4 = '0; rb4 = '0; rr4 = 1;
    #3;
    chk_idle2("rst");
    chk("rst4 req_ready", 64'(rdy4), 64'd0);
    chk("rst4 rsp_valid", 64'(rsp_v4), 64'd0);
    chk("rst4 mul_en", 64'(en4), 64'd0);
    tick();
    rv = '0; rv4 = '0;
    reset = 0;
    tick();
    // basic operation and latency
    ra[31:0] = 32'h00012345; rb[31:0] = 32'h00000010; rv = 2'b01;
    q2.push_back(mk(0, 32'h00012345, 32'h00000010));
    #1;
    chk("t1 gnt", 64'(rdy), 64'd1);
    tick(); rv = '0;
    chk("t1 T+1 mul_en", 64'(en), 64'd1);
    chk("t1 T+1 src1", 64'(s1), 64'h00012345);
    chk("t1 T+1 src2", 64'(s2), 64'h00000010);
    chk("t1 T+1 rsp_valid", 64'(rsp_v), 64'd0);
    tick();
    chk("t1 T+2 mul_en", 64'(en), 64'd0);
    chk("t1 T+2 rsp_valid", 64'(rsp_v), 64'd0);
    tick();
    chk("t1 T+3 rsp_valid", 64'(rsp_v), 64'd1);
    chk("t1 T+3 rsp_data", 64'(rsp_d), 64'h00123450);
    chk("t1 T+3 rsp_id", 64'(rsp_id), 64'd0);
    chk("t1 T+3 mul_en", 64'(en), 64'd0);
    tick();
    chk("t1 T+4 rsp_valid", 64'(rsp_v), 64'd0);
    chk("t1 queue", 64'(q2.size()), 64'd0);
    // wrap-around arithmetic
    op("t2 ones", 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op("t2 hi", 1, 32'h00010000, 32'h00010000);
    // alternating grants, 4-cycle spacing
    ra = {32'd2, 32'd1}; rb = {32'd3, 32'd3}; rv = 2'b11;
    for (int i = 0; i < 4; i++) q2.push_back(mk(i % 2, 32'(i % 2 + 1), 32'd3));
    k = 0; n = 0; last_t = 0;
    #1;
    while (k < 4 && n < 40) begin
      if (rdy != 2'b00) begin
        chk("t3 order", 64'(rdy), (k % 2 == 1) ? 64'd2 : 64'd1);
        if (k > 0) chk("t3 spacing", 64'(n - last_t), 64'd4);
        last_t = n;
        k++;
      end
      if (k < 4) begin
        tick();
        #1;
        n++;
      end
    end
    chk("t3 grants", 64'(k), 64'd4);
    tick(); rv = '0;
    drain("t3 drain", 1'b0);
    // response stall
    ra[31:0] = 32'd7; rb[31:0] = 32'd9; rv = 2'b01; rr = 0;
    q2.push_back(mk(0, 32'd7, 32'd9));
    wait_gnt("t4 gnt", 1'b0, 8'd1);
    tick(); rv = '0;
    tick();
    tick();
    ra[63:32] = 32'd5; rb[63:32] = 32'd5; rv = 2'b10;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("t4 stall rsp_valid", 64'(rsp_v), 64'd1);
      chk("t4 stall rsp_data", 64'(rsp_d), 64'd63);
      chk("t4 stall rsp_id", 64'(rsp_id), 64'd0);
      chk("t4 stall req_ready", 64'(rdy), 64'd0);
      chk("t4 stall mul_en", 64'(en), 64'd0);
      tick();
      #1;
    end
    rr = 1;
    q2.push_back(mk(1, 32'd5, 32'd5));
    tick();
    #1;
    chk("t4 next gnt", 64'(rdy), 64'd2);
    tick(); rv = '0;
    drain("t4 drain", 1'b0);
    // reset in CAPTURE drops the operation
    ra[31:0] = 32'd3; rb[31:0] = 32'd4; rv = 2'b01;
    wait_gnt("t5 gnt0", 1'b0, 8'd1);
    tick(); rv = '0;
    chk("t5 issue mul_en", 64'(en), 64'd1);
    tick();
    reset = 1;
    #1;
    chk_idle2("t5 rst");
    tick();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5 no rsp", 64'(rsp_v), 64'd0);
    end
    ra = {32'd5, 32'h11}; rb = {32'd5, 32'h11}; rv = 2'b11;
    q2.push_back(mk(0, 32'h11, 32'h11));
    wait_gnt("t5 gnt after rst", 1'b0, 8'd1);
    tick(); rv = '0;
    drain("t5 drain", 1'b0);
    // four requesters, skip to the only valid one then rotate
    ra4[127:96] = 32'h100; rb4[127:96] = 32'h100; rv4 = 4'b1000;
    q4.push_back(mk(3, 32'h100, 32'h100));
    wait_gnt("t6 gnt3", 1'b1, 8'h08);
    tick(); rv4 = '0;
    drain("t6 drain3", 1'b1);
    ra4[63:32] = 32'd2; rb4[63:32] = 32'd2; ra4[95:64] = 32'd3; rb4[95:64] = 32'd3; rv4 = 4'b0110;
    q4.push_back(mk(1, 32'd2, 32'd2));
    q4.push_back(mk(2, 32'd3, 32'd3));
    wait_gnt("t6 gnt1", 1'b1, 8'h02);
    tick(); rv4 = 4'b0100;
    wait_gnt("t6 gnt2", 1'b1, 8'h04);
    tick(); rv4 = '0;
    drain("t6 drain", 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mul_cell_sched.md
# mul_cell_sched

Round-robin scheduler that shares one registered 16x16 partial-product multiplier cell among `NUM_REQ` requesters. For each accepted request, the block:

- drives the cell operands and enable,
- captures the three partial products one cycle later,
- folds them into the low 32 bits of a 32x32 product,
- returns the result on a valid/ready response port tagged with the requester ID.

It sits between the custom-logic masters in the sensor subsystem and the single multiplier cell instance.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response ID.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_ready`  out  NUM_REQ: per-requester accept. One-hot or zero.
- `req_a`  in  NUM_REQ*32: operand A, flattened, requester i at bits `[32i+31:32i]`.
- `req_b`  in  NUM_REQ*32: operand B, same layout as `req_a`.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_id`  out  ID_W: index of the requester that owns the response.
- `rsp_data`  out  32: low 32 bits of A*B.
- `mul_src1`  out  32: operand to cell src1.
- `mul_src2`  out  32: operand to cell src2.
- `mul_en`  out  1: cell clock enable.
- `mul_p1`  in  32: cell product a[15:0]*b[15:0].
- `mul_p2`  in  32: cell product a[15:0]*b[31:16].
- `mul_p3`  in  32: cell product a[31:16]*b[15:0].

## Operation
FSM states: IDLE, ISSUE, CAPTURE, RESP.

- **IDLE**
  - The arbiter grants the first requester with `req_valid` high, searching from `last+1` modulo `NUM_REQ`.
  - `req_ready[g]=1` for exactly that requester, combinationally, in the same cycle.
  - On the handshake: latch `req_a[g]` and `req_b[g]` into operand registers, latch `g` into the ID register, update `last=g`, go to ISSUE.
  - No valid requester: stay in IDLE.
- **ISSUE**
  - `mul_en=1`.
  - `mul_src1`/`mul_src2` are driven from the operand registers; they are driven from these registers in every state.
  - The cell registers the products at the end of this cycle. Go to CAPTURE.
- **CAPTURE**
  - `mul_en=0`.
  - `rsp_data_reg <= mul_p1 + ((mul_p2 + mul_p3) << 16)`, truncated to 32 bits. Carries beyond bit 31 are discarded.
  - Go to RESP.
- **RESP**
  - `rsp_valid=1`; `rsp_id` and `rsp_data` are held stable.
  - On `rsp_valid & rsp_ready`: go to IDLE.
  - Holding `rsp_ready` low stalls indefinitely; `req_ready` stays 0.
- **Arithmetic**
  - Unsigned partial products; the 33-bit sum `p2+p3` is shifted, then the total is truncated.
  - The result equals the low 32 bits of A*B for both signed and unsigned interpretations.
- **Ownership of `mul_en`**
  - `mul_en` is asserted only in ISSUE, so the cell holds its products while the block is idle or stalled.
  - No other master may drive `mul_en`.

## Timing
- **Reset values**: `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `mul_src1=0`, `mul_src2=0`, `mul_en=0`. State is IDLE and `last=NUM_REQ-1`, so requester 0 has first priority.
- **Latency**: request handshake at cycle T; `mul_en` high at T+1; `rsp_valid` high at T+3.
- **Throughput**:
  - 4 cycles per operation when `rsp_ready` is held high.
  - The next grant can occur in the cycle after the response handshake. There is no overlap: at most one operation is in flight.
- **Fairness**:
  - A requester that stays valid is served within `NUM_REQ` operations.
  - A requester that deasserts `req_valid` before being granted is simply skipped.
- **Reset during an operation**:
  - Asynchronous return to IDLE with all outputs at reset values.
  - The in-flight result is dropped and no response is issued.
  - `mul_en` drops immediately.
- **`rsp_ready` already high on entry to RESP**: the handshake completes in the first RESP cycle.

## Structure
- Package `mul_cell_sched_pkg`:
  - `state_t` enum (IDLE, ISSUE, CAPTURE, RESP),
  - constant `PP_SHIFT=16`,
  - function `fold_pp(p1,p2,p3)` returning the 32-bit result.
- Sub-module `rr_arbiter`, parameterized by `NUM_REQ`:
  - inputs: request vector, `last` pointer, enable,
  - outputs: one-hot grant and its encoded index.
- The FSM, operand, ID and result registers live in the top module.

## Test plan
1. Requester 0 sends A=0x00012345, B=0x00000010, `rsp_ready=1` -> `mul_en` high exactly 1 cycle; `rsp_valid` 3 cycles after the handshake with `rsp_data=0x00123450`, `rsp_id=0`.
2. A=0xFFFFFFFF, B=0xFFFFFFFF -> `rsp_data=0x00000001`. A=0x00010000, B=0x00010000 -> `rsp_data=0x00000000`.
3. Both requesters valid continuously for 4 operations -> grant order 0,1,0,1; each response ID matches its operands. Use A=i+1 per requester, B=3.
4. `rsp_ready` held low 10 cycles in RESP -> `rsp_valid`, `rsp_data` and `rsp_id` stable; `req_ready` and `mul_en` stay 0. Release -> next grant one cycle later.
5. Assert `reset` in the CAPTURE cycle -> outputs zero immediately, no response; the next request after release is served normally starting with requester 0.
6. With `NUM_REQ=4`, only requester 3 valid, then requesters 1 and 2 valid -> grants 3, 1, 2 in that order.
